// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types, constants and the baud divider helper for uart_rx
package uart_rx_pkg;
    localparam int DATA_BITS = 8;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: oversample enable, one pulse every DIV clocks; restart zeroes the phase
// Ports: clk, reset (async, active-low), restart (sync), en (enable pulse)
module uart_baud_gen #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic en
);
    localparam int W = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt <= '0;
        else        cnt <= (restart || cnt == LAST) ? '0 : cnt + 1'b1;
    end
    assign en = !restart && cnt == LAST;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, oversampled, mid-bit sampling
// Ports: clk, reset (async, active-low), rxd (serial in), rx_done (byte strobe),
//        data_out (last good byte), tick (bit boundary strobe), frame_err (with UART_RX_FRAME_ERR_EN)
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    output logic                 rx_done,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 tick
`ifdef UART_RX_FRAME_ERR_EN
    ,
    output logic                 frame_err
`endif
);
    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);

    state_t               state, state_nx;
    logic                 rxd_m, rxd_s, armed;
    logic [1:0]           settle;
    logic [SW-1:0]        scnt;
    logic [2:0]           idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 en, start, mid, bnd, done_nx;

    uart_baud_gen #(.DIV(DIV)) u_baud (
        .clk     (clk),
        .reset   (reset),
        .restart (start),
        .en      (en)
    );

    // armed means the line has been seen high in IDLE, so a low level is a real falling edge;
    // settle masks the synchronizer's reset value so a line held low at reset never arms
    assign start = state == IDLE && armed && !rxd_s;
    assign mid   = en && scnt == S_MID;
    assign bnd   = en && scnt == S_END;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = START;
            START:   if (mid && rxd_s) state_nx = IDLE;
                     else if (bnd) state_nx = DATA;
            DATA:    if (bnd && idx == 3'(DATA_BITS - 1)) state_nx = STOP;
            STOP:    if (mid) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        tick    = bnd && (state == START || state == DATA);
        done_nx = state == STOP && mid && rxd_s;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxd_m    <= 1'b1;
            rxd_s    <= 1'b1;
            settle   <= '0;
            armed    <= 1'b0;
            scnt     <= '0;
            idx      <= '0;
            shreg    <= '0;
            data_out <= '0;
            rx_done  <= 1'b0;
        end else begin
            rxd_m    <= rxd;
            rxd_s    <= rxd_m;
            settle   <= {settle[0], 1'b1};
            armed    <= state == IDLE && !start && (armed || (settle[1] && rxd_s));
            scnt     <= start ? '0 : en ? (scnt == S_END ? '0 : scnt + 1'b1) : scnt;
            idx      <= start ? '0 : (state == DATA && bnd) ? idx + 1'b1 : idx;
            if (state == DATA && mid) shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
            if (done_nx) data_out <= shreg;
            rx_done  <= done_nx;
        end
    end

`ifdef UART_RX_FRAME_ERR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) frame_err <= 1'b0;
        else        frame_err <= state == STOP && mid && !rxd_s;
    end
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx at default parameters
module tb_uart_rx;
    import uart_rx_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rxd = 1'b1;
    logic       rx_done, tick;
    logic [7:0] data_out;
    int         checks = 0, errors = 0;
    int         cyc = 0, tick_cnt = 0, done_cnt = 0, ferr_cnt = 0;
    int         t_start = 0, t_done = 0;
    int         tk0, dn0, fe0;
    bit         ok;

`ifdef UART_RX_FRAME_ERR_EN
    logic frame_err;
`endif

    uart_rx dut (
        .clk      (clk),
        .reset    (reset),
        .rxd      (rxd),
        .rx_done  (rx_done),
        .data_out (data_out),
        .tick     (tick)
`ifdef UART_RX_FRAME_ERR_EN
        ,
        .frame_err(frame_err)
`endif
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (tick) tick_cnt++;
        if (rx_done) done_cnt++;
`ifdef UART_RX_FRAME_ERR_EN
        if (frame_err) ferr_cnt++;
`endif
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tick(output bit got);
        got = 1'b0;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            got = tick;
        end
    endtask

    // start bit, then each data bit is driven right after the tick that ends the previous bit
    task automatic send(input logic [7:0] b, input bit stop, output bit all_ok);
        bit g;
        all_ok = 1'b1;
        @(negedge clk);
        rxd = 1'b0;
        t_start = cyc;
        wait_tick(g);
        all_ok &= g;
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_tick(g);
            all_ok &= g;
        end
        rxd = stop;
        if (stop) begin
            g = 1'b0;
            for (int i = 0; i < 600 && !g; i++) begin
                @(negedge clk);
                g = rx_done;
            end
            t_done = cyc;
            all_ok &= g;
            repeat (200) @(negedge clk);
        end else begin
            repeat (432) @(negedge clk);
        end
    endtask

    initial begin
        #11;
        chk("reset_rx_done", rx_done, 1'b0);
        chk("reset_tick", tick, 1'b0);
        chk("reset_data_out", data_out, 8'h00);
`ifdef UART_RX_FRAME_ERR_EN
        chk("reset_frame_err", frame_err, 1'b0);
`endif
        reset = 1'b1;
        repeat (50) @(negedge clk);

        tk0 = tick_cnt; dn0 = done_cnt;
        send(8'h55, 1'b1, ok);
        chk("f55_progress", ok, 1'b1);
        chk("f55_ticks", tick_cnt - tk0, 9);
        chk("f55_done_count", done_cnt - dn0, 1);
        chk("f55_data", data_out, 8'h55);
        chk("f55_latency_ok", (t_done - t_start >= 4104) && (t_done - t_start <= 4112), 1'b1);

        tk0 = tick_cnt; dn0 = done_cnt;
        send(8'hA3, 1'b1, ok);
        chk("fa3_progress", ok, 1'b1);
        chk("fa3_data", data_out, 8'hA3);
        chk("fa3_done_count", done_cnt - dn0, 1);
        send(8'h0F, 1'b1, ok);
        chk("f0f_progress", ok, 1'b1);
        chk("f0f_data", data_out, 8'h0F);
        chk("b2b_done_count", done_cnt - dn0, 2);
        chk("b2b_ticks", tick_cnt - tk0, 18);

        tk0 = tick_cnt; dn0 = done_cnt;
        rxd = 1'b0;
        repeat (5) @(negedge clk);
        rxd = 1'b1;
        repeat (600) @(negedge clk);
        chk("glitch_ticks", tick_cnt - tk0, 0);
        chk("glitch_done", done_cnt - dn0, 0);
        chk("glitch_idle", dut.state, IDLE);

        tk0 = tick_cnt; dn0 = done_cnt; fe0 = ferr_cnt;
        send(8'h99, 1'b0, ok);
        chk("ferr_progress", ok, 1'b1);
        chk("ferr_ticks", tick_cnt - tk0, 9);
        chk("ferr_no_done", done_cnt - dn0, 0);
        chk("ferr_data_kept", data_out, 8'h0F);
`ifdef UART_RX_FRAME_ERR_EN
        chk("ferr_pulse", ferr_cnt - fe0, 1);
`endif
        tk0 = tick_cnt;
        repeat (1000) @(negedge clk);
        chk("ferr_no_rearm_low", tick_cnt - tk0, 0);
        chk("ferr_idle", dut.state, IDLE);
        rxd = 1'b1;
        repeat (100) @(negedge clk);

        dn0 = done_cnt;
        rxd = 1'b0;
        wait_tick(ok);
        for (int i = 0; i < 4; i++) begin
            rxd = 1'b1;
            wait_tick(ok);
        end
        rxd = 1'b0;
        repeat (100) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_rx_done", rx_done, 1'b0);
        chk("midrst_tick", tick, 1'b0);
        chk("midrst_data_out", data_out, 8'h00);
        chk("midrst_idle", dut.state, IDLE);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (50) @(negedge clk);
        chk("midrst_no_done", done_cnt - dn0, 0);
        send(8'h3C, 1'b1, ok);
        chk("f3c_progress", ok, 1'b1);
        chk("f3c_data", data_out, 8'h3C);

        rxd = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        tk0 = tick_cnt;
        repeat (1500) @(negedge clk);
        chk("lowline_ticks", tick_cnt - tk0, 0);
        chk("lowline_idle", dut.state, IDLE);
        rxd = 1'b1;
        repeat (50) @(negedge clk);
        dn0 = done_cnt;
        send(8'h81, 1'b1, ok);
        chk("f81_progress", ok, 1'b1);
        chk("f81_data", data_out, 8'h81);
        chk("f81_done_count", done_cnt - dn0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
